// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and destination-field positions, also used by the 4x4 arbiter.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 6;
  localparam int unsigned FIFO_ADDR_WIDTH = 2;
  localparam int unsigned DEST_MSB        = FIFO_DATA_WIDTH - 1;
  localparam int unsigned DEST_LSB        = FIFO_DATA_WIDTH - 2;

  // Default-width word layout: 2-bit destination on top, payload below.
  typedef struct packed {
    logic [DEST_MSB-DEST_LSB:0] dest;
    logic [DEST_LSB-1:0]        payload;
  } fifo_word_t;

endpackage

// File: rtl/fifo_umbral_if.sv
// FIFO push/pop bus: master is the producer/consumer, slave is the FIFO.
interface fifo_umbral_if #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH
);

  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, data_in, pop,
    input  data_out, full, empty, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, full, empty, almost_full, almost_empty, count, error
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH two-port array; synchronous write, registered read cleared on reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_umbral.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and sticky error.
module fifo_umbral #(
  parameter int unsigned DATA_WIDTH = fifo_pkg::FIFO_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH,
  parameter int unsigned AF_THRESH  = 3,
  parameter int unsigned AE_THRESH  = 1
) (
  input logic         clk,
  input logic         reset,
  fifo_umbral_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  if (AF_THRESH < 1 || AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("fifo_umbral: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  error_q, error_d;
  logic                  full_c, empty_c;
  logic                  push_acc_c, pop_acc_c;

  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  // A push at full is still accepted when a pop frees the slot in the same cycle.
  always_comb begin
    pop_acc_c  = bus.pop && !empty_c;
    push_acc_c = bus.push && (!full_c || pop_acc_c);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    error_d    = error_q;
    if (push_acc_c) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop_acc_c) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (push_acc_c && !pop_acc_c) begin
      count_d = count_q + CW'(1);
    end else if (pop_acc_c && !push_acc_c) begin
      count_d = count_q - CW'(1);
    end
    if ((bus.push && !push_acc_c) || (bus.pop && empty_c)) begin
      error_d = 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_acc_c && !reset),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in),
    .re    (pop_acc_c && !reset),
    .raddr (rd_ptr_q),
    .rdata (bus.data_out)
  );

  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_fifo_umbral.sv
// Directed self-checking bench for fifo_umbral at default parameters (depth 4, AF 3, AE 1).
module tb_fifo_umbral;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fifo_umbral_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus ();

  fifo_umbral #(
    .DATA_WIDTH (6),
    .ADDR_WIDTH (2),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, settle just after it.
  task automatic cyc(input logic p, input logic [5:0] d, input logic q);
    bus.push    = p;
    bus.data_in = d;
    bus.pop     = q;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, 1'b0);
    reset = 1'b0;
  endtask

  logic [5:0] fill_a [4] = '{6'h11, 6'h22, 6'h33, 6'h04};
  logic [5:0] fill_b [4] = '{6'h01, 6'h02, 6'h03, 6'h05};
  logic [5:0] fill_c [4] = '{6'h21, 6'h22, 6'h23, 6'h24};

  initial begin
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    reset       = 1'b1;
    #1;
    do_reset(2);

    check("rst_empty",  32'(bus.empty), 32'd1);
    check("rst_aempty", 32'(bus.almost_empty), 32'd1);
    check("rst_full",   32'(bus.full), 32'd0);
    check("rst_afull",  32'(bus.almost_full), 32'd0);
    check("rst_count",  32'(bus.count), 32'd0);
    check("rst_dout",   32'(bus.data_out), 32'd0);
    check("rst_error",  32'(bus.error), 32'd0);

    // Fill: count 1..4, almost_full from 3, full at 4, almost_empty only at 1.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, fill_a[i], 1'b0);
      check("fill_count",  32'(bus.count), 32'(i + 1));
      check("fill_empty",  32'(bus.empty), 32'd0);
      check("fill_aempty", 32'(bus.almost_empty), (i == 0) ? 32'd1 : 32'd0);
      check("fill_afull",  32'(bus.almost_full), (i >= 2) ? 32'd1 : 32'd0);
      check("fill_full",   32'(bus.full), (i == 3) ? 32'd1 : 32'd0);
    end

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("drain_dout",  32'(bus.data_out), 32'(fill_a[i]));
      check("drain_count", 32'(bus.count), 32'(3 - i));
      check("drain_full",  32'(bus.full), 32'd0);
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_error", 32'(bus.error), 32'd0);

    // Overflow: push at full is dropped and flags error.
    for (int i = 0; i < 4; i++) cyc(1'b1, fill_b[i], 1'b0);
    check("ovf_pre_err", 32'(bus.error), 32'd0);
    cyc(1'b1, 6'h3F, 1'b0);
    check("ovf_count", 32'(bus.count), 32'd4);
    check("ovf_error", 32'(bus.error), 32'd1);
    check("ovf_full",  32'(bus.full), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("ovf_drain", 32'(bus.data_out), 32'(fill_b[i]));
    end
    check("ovf_empty", 32'(bus.empty), 32'd1);

    // Underflow with simultaneous push: push taken, pop ignored, data_out holds.
    cyc(1'b1, 6'h15, 1'b1);
    check("udf_error", 32'(bus.error), 32'd1);
    check("udf_count", 32'(bus.count), 32'd1);
    check("udf_dout",  32'(bus.data_out), 32'h05);
    cyc(1'b0, 6'h00, 1'b1);
    check("udf_next",  32'(bus.data_out), 32'h15);
    check("udf_cnt0",  32'(bus.count), 32'd0);

    do_reset(1);
    check("rst2_error", 32'(bus.error), 32'd0);
    check("rst2_dout",  32'(bus.data_out), 32'd0);

    // Stream push+pop at full for 8 cycles; pointers wrap twice.
    for (int i = 0; i < 4; i++) cyc(1'b1, fill_c[i], 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 6'(32'h30 + i), 1'b1);
      check("strm_dout",  32'(bus.data_out), (i < 4) ? 32'(fill_c[i]) : 32'(32'h30 + i - 4));
      check("strm_count", 32'(bus.count), 32'd4);
      check("strm_full",  32'(bus.full), 32'd1);
    end
    check("strm_error", 32'(bus.error), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("strm_drain", 32'(bus.data_out), 32'(32'h34 + i));
    end
    check("strm_empty", 32'(bus.empty), 32'd1);

    // Reset mid-stream discards contents.
    cyc(1'b1, 6'h0A, 1'b0);
    cyc(1'b1, 6'h0B, 1'b0);
    check("mid_count2", 32'(bus.count), 32'd2);
    do_reset(1);
    check("mid_count", 32'(bus.count), 32'd0);
    check("mid_empty", 32'(bus.empty), 32'd1);
    check("mid_dout",  32'(bus.data_out), 32'd0);
    cyc(1'b1, 6'h1C, 1'b0);
    cyc(1'b0, 6'h00, 1'b1);
    check("mid_new",   32'(bus.data_out), 32'h1C);
    check("mid_cnt0",  32'(bus.count), 32'd0);
    check("mid_error", 32'(bus.error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
